m706_rcv: RTL and testbench

M706_RCV -- requirements
Module: m706_rcv

---
 rtl/m706_pkg.sv | 20 ++
 rtl/m706_sync.sv | 26 ++
 rtl/m706_rcv.sv | 169 ++++++++++++++++
 tb/tb_m706_rcv.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m706_pkg.sv
// m706_pkg -- shared definitions for the m706 serial receiver.
//   rcv_state_t  : receiver FSM state encoding
//   DEV_CODE_DEF : default IOT device code the receiver answers to
//   IOPn_BIT     : bit positions of the IOP pulses inside the packed iop vector
package m706_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rcv_state_t;

  localparam logic [5:0] DEV_CODE_DEF = 6'o03;

  localparam int IOP1_BIT = 0;
  localparam int IOP2_BIT = 1;
  localparam int IOP4_BIT = 2;

endpackage

// File: rtl/m706_sync.sv
// m706_sync -- two-flop synchronizer for the asynchronous serial line.
// Ports:
//   clk     : system clock
//   io_clr  : synchronous active-high reset; both stages reset to mark (1)
//   line_in : raw serial line
//   line_s  : synchronized line
module m706_sync (
  input  logic clk,
  input  logic io_clr,
  input  logic line_in,
  output logic line_s
);

  logic meta;

  always_ff @(posedge clk) begin
    if (io_clr) begin
      meta   <= 1'b1;
      line_s <= 1'b1;
    end else begin
      meta   <= line_in;
      line_s <= meta;
    end
  end

endmodule

// File: rtl/m706_rcv.sv
// m706_rcv -- oversampled serial receiver with IOT bus interface.
// Optional build macro: M706_STOP_CHECK_EN (stop-bit framing check drives frm_err).
// Ports:
//   clk, io_clr          : clock, synchronous active-high reset
//   bit_tick             : one-clk pulse at OVERSAMPLE x baud
//   line_in              : serial line, 1 = mark/idle
//   dev_sel              : IOT device-select field
//   iop1, iop2, iop4     : IOP pulses
//   rx_data              : receive buffer, bit 0 = first data bit
//   bus_out              : rx_data during a selected iop4, else 0
//   flag, int_req        : character ready
//   skip, ac_clr         : combinational IOT responses
//   active               : frame in progress
//   frm_err              : stop bit was 0 (only with M706_STOP_CHECK_EN)
//
// state    | meaning
// ST_IDLE  | waiting for a falling edge on an armed (seen-idle) line
// ST_START | counting to mid start bit to reject glitches
// ST_DATA  | sampling 8 data bits, one per OVERSAMPLE ticks
// ST_STOP  | waiting for stop sample, then load buffer and set flag
module m706_rcv
  import m706_pkg::*;
#(
  parameter logic [5:0] DEV_CODE   = DEV_CODE_DEF,
  parameter int         OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       io_clr,
  input  logic       bit_tick,
  input  logic       line_in,
  input  logic [5:0] dev_sel,
  input  logic       iop1,
  input  logic       iop2,
  input  logic       iop4,
  output logic [7:0] rx_data,
  output logic [7:0] bus_out,
  output logic       flag,
  output logic       int_req,
  output logic       skip,
  output logic       ac_clr,
  output logic       active,
  output logic       frm_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_WRAP = TW'(OVERSAMPLE - 1);

  logic          line_s;
  logic [2:0]    iop_v;
  logic          sel;
  logic          flag_clr;

  rcv_state_t    state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          armed, armed_n;
  logic          frame_done;

  m706_sync u_sync (
    .clk     (clk),
    .io_clr  (io_clr),
    .line_in (line_in),
    .line_s  (line_s)
  );

  always_comb begin
    iop_v           = '0;
    iop_v[IOP1_BIT] = iop1;
    iop_v[IOP2_BIT] = iop2;
    iop_v[IOP4_BIT] = iop4;
  end

  assign sel      = (dev_sel == DEV_CODE);
  assign flag_clr = sel & (iop_v[IOP2_BIT] | iop_v[IOP4_BIT]);
  assign skip     = sel & iop_v[IOP1_BIT] & flag;
  assign ac_clr   = sel & iop_v[IOP2_BIT];
  assign bus_out  = (sel & iop_v[IOP4_BIT]) ? rx_data : 8'h00;
  assign int_req  = flag;
  assign active   = (state != ST_IDLE);

  always_comb begin
    state_n    = state;
    tcnt_n     = tcnt;
    bcnt_n     = bcnt;
    shreg_n    = shreg;
    armed_n    = armed;
    frame_done = 1'b0;
    if (bit_tick) begin
      case (state)
        ST_IDLE: begin
          // A start edge only counts once the line has been seen idle,
          // so a line stuck low after a bad stop bit cannot retrigger.
          if (line_s) begin
            armed_n = 1'b1;
          end else if (armed) begin
            state_n = ST_START;
            tcnt_n  = '0;
          end
        end
        ST_START: begin
          if (tcnt == T_HALF) begin
            if (!line_s) begin
              state_n = ST_DATA;
              tcnt_n  = '0;
              bcnt_n  = '0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        ST_DATA: begin
          tcnt_n = tcnt + 1'b1;
          if (tcnt == T_WRAP) begin
            shreg_n = {line_s, shreg[7:1]};
            bcnt_n  = bcnt + 3'd1;
            if (bcnt == 3'd7) state_n = ST_STOP;
          end
        end
        ST_STOP: begin
          tcnt_n = tcnt + 1'b1;
          if (tcnt == T_WRAP) begin
            frame_done = 1'b1;
            armed_n    = 1'b0;
            state_n    = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (io_clr) begin
      state   <= ST_IDLE;
      tcnt    <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      armed   <= 1'b0;
      rx_data <= '0;
      flag    <= 1'b0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      shreg <= shreg_n;
      armed <= armed_n;
      if (frame_done) rx_data <= shreg;
      // set beats a simultaneous selected clear
      flag <= frame_done | (flag & ~flag_clr);
    end
  end

`ifdef M706_STOP_CHECK_EN
  logic frm_err_q;
  always_ff @(posedge clk) begin
    if (io_clr)          frm_err_q <= 1'b0;
    else if (frame_done) frm_err_q <= ~line_s;
    else if (flag_clr)   frm_err_q <= 1'b0;
  end
  assign frm_err = frm_err_q;
`else
  assign frm_err = 1'b0;
`endif

endmodule

// File: tb/tb_m706_rcv.sv
module tb_m706_rcv;

  localparam int OS = 8;
`ifdef M706_STOP_CHECK_EN
  localparam bit STOP_CHK = 1'b1;
`else
  localparam bit STOP_CHK = 1'b0;
`endif

  logic       clk;
  logic       io_clr;
  logic       bit_tick;
  logic       line_in;
  logic [5:0] d_dev, r_dev;
  logic       d_iop1, d_iop2, d_iop4;
  logic       r_iop1, r_iop2, r_iop4;
  logic       rand_en;
  wire  [5:0] dev_w  = rand_en ? r_dev  : d_dev;
  wire        iop1_w = rand_en ? r_iop1 : d_iop1;
  wire        iop2_w = rand_en ? r_iop2 : d_iop2;
  wire        iop4_w = rand_en ? r_iop4 : d_iop4;

  logic [7:0] rx_data, bus_out;
  logic       flag, int_req, skip, ac_clr, active, frm_err;

  int cmp_tests = 0, cmp_fails = 0, lit_tests = 0, lit_fails = 0;
  int div = 0;

  m706_rcv dut (
    .clk      (clk),
    .io_clr   (io_clr),
    .bit_tick (bit_tick),
    .line_in  (line_in),
    .dev_sel  (dev_w),
    .iop1     (iop1_w),
    .iop2     (iop2_w),
    .iop4     (iop4_w),
    .rx_data  (rx_data),
    .bus_out  (bus_out),
    .flag     (flag),
    .int_req  (int_req),
    .skip     (skip),
    .ac_clr   (ac_clr),
    .active   (active),
    .frm_err  (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit_tick every third clk
  initial bit_tick = 1'b0;
  always @(negedge clk) begin
    div = (div == 2) ? 0 : div + 1;
    bit_tick = (div == 0);
  end

  // random IOP traffic, only muxed onto the DUT while rand_en=1
  initial begin r_iop1 = 0; r_iop2 = 0; r_iop4 = 0; r_dev = 6'o03; end
  always @(negedge clk) begin
    r_dev  = ($urandom_range(0, 1) == 0) ? 6'o03 : 6'($urandom_range(0, 63));
    r_iop1 = ($urandom_range(0, 15) == 0);
    r_iop2 = ($urandom_range(0, 40) == 0);
    r_iop4 = ($urandom_range(0, 40) == 0);
  end

  // Behavioural model: a frame is timed by the number of ticks since the
  // falling edge was accepted. Mid start bit is OS/2 ticks later, data bit i
  // is sampled OS*(i+1) ticks after that, the stop bit OS*9 ticks after it.
  logic       m_s1, m_s2, m_armed, m_busy, m_flag, m_frm;
  logic [7:0] m_data, m_rx;
  int         m_n;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    logic clr, done;
    int   k;
    if (io_clr) begin
      m_s1 = 1; m_s2 = 1; m_armed = 0; m_busy = 0; m_n = 0;
      m_data = 0; m_rx = 0; m_flag = 0; m_frm = 0; m_valid = 1;
    end else begin
      done = 0;
      clr  = (dev_w == 6'o03) && (iop2_w || iop4_w);
      if (bit_tick) begin
        if (!m_busy) begin
          if (m_s2) m_armed = 1;
          else if (m_armed) begin m_busy = 1; m_n = 0; end
        end else begin
          m_n++;
          if (m_n == OS / 2) begin
            if (m_s2) m_busy = 0;
          end else if (m_n > OS / 2 && (m_n - OS / 2) % OS == 0) begin
            k = (m_n - OS / 2) / OS;
            if (k <= 8) m_data[k-1] = m_s2;
            else begin done = 1; m_busy = 0; m_armed = 0; end
          end
        end
      end
      if (done) begin
        m_rx = m_data; m_flag = 1; m_frm = STOP_CHK ? !m_s2 : 1'b0;
      end else if (clr) begin
        m_flag = 0; m_frm = 0;
      end
      m_s2 = m_s1;
      m_s1 = line_in;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_tests++;
    if (act !== exp) begin
      cmp_fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("rx_data", 32'(rx_data), 32'(m_rx));
      chk("flag",    32'(flag),    32'(m_flag));
      chk("int_req", 32'(int_req), 32'(m_flag));
      chk("active",  32'(active),  32'(m_busy));
      chk("frm_err", 32'(frm_err), 32'(m_frm));
      chk("skip",    32'(skip),    32'(iop1_w && dev_w == 6'o03 && m_flag));
      chk("ac_clr",  32'(ac_clr),  32'(iop2_w && dev_w == 6'o03));
      chk("bus_out", 32'(bus_out), 32'((iop4_w && dev_w == 6'o03) ? m_rx : 8'h00));
    end
  end

  task automatic lcheck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_tests++;
    if (act !== exp) begin
      lit_fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (bit_tick) c++;
    end
    @(negedge clk);
  endtask

  // leaves the line at the stop level; caller returns it to idle
  task automatic send_frame(input logic [7:0] d, input logic stp);
    line_in = 0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      line_in = d[i];
      wait_ticks(OS);
    end
    line_in = stp;
    wait_ticks(OS);
  endtask

  initial begin
    line_in = 1; io_clr = 1; rand_en = 0;
    d_dev = 6'o03; d_iop1 = 0; d_iop2 = 0; d_iop4 = 0;
    repeat (3) @(negedge clk);
    io_clr = 0;
    lcheck("reset_rx", 32'(rx_data), 32'h0);
    lcheck("reset_flag", 32'(flag), 32'h0);
    lcheck("reset_active", 32'(active), 32'h0);
    wait_ticks(2);

    send_frame(8'h41, 1'b1);
    line_in = 1;
    wait_ticks(2);
    lcheck("frame41_rx", 32'(rx_data), 32'h41);
    lcheck("frame41_flag", 32'(flag), 32'h1);
    lcheck("frame41_int", 32'(int_req), 32'h1);

    d_dev = 6'o03; d_iop1 = 1; #1;
    lcheck("skip_sel", 32'(skip), 32'h1);
    @(negedge clk); d_dev = 6'o04; #1;
    lcheck("skip_unsel", 32'(skip), 32'h0);
    @(negedge clk); d_iop1 = 0; d_dev = 6'o03; d_iop4 = 1; #1;
    lcheck("bus_out_iop4", 32'(bus_out), 32'h41);
    @(negedge clk); d_iop4 = 0;
    lcheck("flag_clr_iop4", 32'(flag), 32'h0);
    d_iop2 = 1; #1;
    lcheck("ac_clr_sel", 32'(ac_clr), 32'h1);
    @(negedge clk); d_iop2 = 0;

    line_in = 0;
    wait_ticks(3);
    lcheck("false_start_active", 32'(active), 32'h1);
    line_in = 1;
    wait_ticks(OS);
    lcheck("false_start_idle", 32'(active), 32'h0);
    lcheck("false_start_flag", 32'(flag), 32'h0);

    send_frame(8'h41, 1'b1);
    line_in = 1;
    wait_ticks(OS);
    send_frame(8'h7F, 1'b1);
    line_in = 1;
    wait_ticks(2);
    lcheck("overrun_rx", 32'(rx_data), 32'h7F);
    lcheck("overrun_flag", 32'(flag), 32'h1);

    line_in = 0;
    wait_ticks(OS);
    line_in = 1;
    wait_ticks(4);
    io_clr = 1;
    @(negedge clk); io_clr = 0;
    lcheck("clr_rx", 32'(rx_data), 32'h0);
    lcheck("clr_flag", 32'(flag), 32'h0);
    lcheck("clr_active", 32'(active), 32'h0);
    lcheck("clr_frm", 32'(frm_err), 32'h0);
    wait_ticks(2 * OS);

`ifdef M706_STOP_CHECK_EN
    send_frame(8'h55, 1'b0);
    wait_ticks(2);
    lcheck("stopbad_rx", 32'(rx_data), 32'h55);
    lcheck("stopbad_flag", 32'(flag), 32'h1);
    lcheck("stopbad_frm", 32'(frm_err), 32'h1);
    wait_ticks(2 * OS);
    lcheck("stopbad_no_restart", 32'(active), 32'h0);
    line_in = 1;
    wait_ticks(OS);
    d_dev = 6'o03; d_iop2 = 1;
    @(negedge clk); d_iop2 = 0;
    lcheck("frm_clr", 32'(frm_err), 32'h0);
`endif

    rand_en = 1;
    for (int f = 0; f < 30; f++) begin
      line_in = 1;
      wait_ticks($urandom_range(0, 2 * OS));
      if ($urandom_range(0, 4) == 0) begin
        line_in = 0;
        wait_ticks($urandom_range(1, OS / 2 - 1));
        line_in = 1;
        wait_ticks(OS);
      end
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
    end
    rand_en = 0;
    line_in = 1;
    wait_ticks(2 * OS);

    $display("[TB] %0d tests run, %0d failed", cmp_tests + lit_tests, cmp_fails + lit_fails);
    $finish;
  end

endmodule
